keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
// Sequences a 4x4 matrix keypad: steps the row drive, synchronizes and debounces the column
// returns, and emits exactly one key event per physical press. It also keeps a two-key history
// for the dual seven-segment display. Sits between the keypad pins and the display mux.
// PARAMETERS
// SCAN_DIV   2400  clk cycles per scan tick (row dwell time); must be >= 1
// DB_TICKS   10    consecutive matching scan ticks needed to accept a press or a release; >= 1
// PORTS
// clk         in   1  system clock
// reset       in   1  synchronous, active-high reset
// columns     in   4  raw keypad column returns, asynchronous, active-low (0 = pressed); [3] = leftmost
// rows        out  4  one-hot row drive, active-high; [3] = top row
// key_valid   out  1  one-clk pulse: new debounced key accepted
// key_code    out  4  hex code of the last accepted key (held between pulses)
// digit_hi    out  4  previous accepted key (older display digit)
// digit_lo    out  4  most recent accepted key (newer display digit)
// BEHAVIOUR
// - Reset values: rows=4'b1000, key_valid=0, key_code=0, digit_hi=0, digit_lo=0, state SCAN, all counters 0.
// - Reset takes priority over any tick or key event in the same cycle.
// - columns pass through a 2-flop synchronizer (col_s); all decisions use col_s and are taken only on scan tick cycles.
// - Tick: divider counts 0..SCAN_DIV-1; the tick is high for one clk at the wrap. With SCAN_DIV=1, every cycle is a tick.
// - A press is "single" when exactly one bit of col_s is 0. Two or more zero bits are treated as no press.
// - FSM:
//   SCAN     On a tick with a single press: latch row_sel=rows and col_sel=that column, clear db_cnt, go to DEBOUNCE.
//            The row does not advance on that tick. Otherwise, on a tick, rotate rows 1000->0100->0010->0001->1000.
//   DEBOUNCE rows frozen. On each tick: if col_s == single press at col_sel, db_cnt++, else return to SCAN.
//            When db_cnt reaches DB_TICKS: key_valid=1 on the next clk, key_code=decode(row_sel,col_sel),
//            digit_hi<=digit_lo, digit_lo<=code; go to HELD.
//            When returning to SCAN, rows advance to the next row on that same tick.
//   HELD     rows frozen. Only the col_sel bit is watched; other keys are ignored.
//            On a tick with col_s[col_sel]=1: clear db_cnt, go to RELEASE.
//   RELEASE  On each tick: if col_s[col_sel]=1, db_cnt++, else go back to HELD (no new pulse).
//            When db_cnt reaches DB_TICKS, go to SCAN with rows advanced to the next row.
// - Latency: key_valid rises 1 clk after the DB_TICKS-th confirming tick that follows the detection tick.
//   Input-to-detect latency also includes 2 clk of synchronizer delay.
// - key_valid is never asserted outside the DEBOUNCE->HELD transition, so there is at most one pulse per press.
// - Decode (top row to bottom, left column to right): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
// - Widths: divider $clog2(SCAN_DIV+1) bits, db_cnt $clog2(DB_TICKS+1) bits; both saturate-free because they always clear on exit.
// STRUCTURE
// - keypad_pkg: state typedef {SCAN, DEBOUNCE, HELD, RELEASE}; ROW_TOP=4'b1000 constant;
//   function key_decode(rows[3:0], col_idx[1:0]) -> [3:0].
// - Sub-module scan_tick_gen #(SCAN_DIV) (clk, reset, tick): the divider only.
//   Synchronizer, FSM and history registers stay in this module.
// TESTING (SCAN_DIV=4, DB_TICKS=3)
// - Reset, columns=4'b1111 -> rows=1000; rows=0100 after 4 clk, 0001 after 12 clk, 1000 after 16 clk; key_valid never high.
// - Hold columns=4'b1101 while rows=0100 -> one key_valid, key_code=4'h6, digit_lo=6, digit_hi=0; rows stay 0100 while held.
// - Press 5, release, then press 9 (each stable) -> two pulses; digit_hi=5, digit_lo=9.
// - Key low for 2 ticks, then high -> no key_valid; scan resumes at the next row.
// - Hold 20 ticks, then release with a 1-tick bounce low -> exactly one pulse; SCAN resumes 3 ticks after the final release.
// - columns=4'b1001 (two keys) -> no detection; reset asserted mid-DEBOUNCE -> all outputs take reset values, no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, top-row constant,
// and the row/column to hex-key decode table.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] ROW_TOP = 4'b1000;

    // col_idx 3 is the leftmost column, so each table row reads left to right from the MSB nibble.
    function automatic logic [3:0] key_decode(input logic [3:0] row, input logic [1:0] col_idx);
        logic [15:0] line;
        case (row)
            4'b1000: line = 16'h123A;
            4'b0100: line = 16'h456B;
            4'b0010: line = 16'h789C;
            default: line = 16'hE0FD;
        endcase
        return line[{col_idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan-rate divider: counts 0..SCAN_DIV-1 and raises tick for the one cycle at the wrap.
module scan_tick_gen #(
    parameter int SCAN_DIV = 2400
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(SCAN_DIV + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row stepping, column synchronizer, press/release debounce FSM,
// one key_valid pulse per accepted press, and a two-digit display history.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 2400,
    parameter int DB_TICKS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo
);

    localparam int DW = $clog2(DB_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS);

    logic          tick;
    logic [3:0]    col_m_q, col_s_q;
    state_t        state_q, state_d;
    logic [3:0]    rows_q, rows_d, row_sel_q, row_sel_d;
    logic [1:0]    col_sel_q, col_sel_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d, db_inc;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    digit_hi_q, digit_hi_d, digit_lo_q, digit_lo_d;
    logic          single;
    logic [1:0]    single_idx;
    logic [3:0]    press_mask, rows_next, new_code;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Only exactly one low column counts as a press; ghosted multi-key patterns are ignored.
    always_comb begin
        single     = 1'b0;
        single_idx = 2'd0;
        case (col_s_q)
            4'b0111: begin single = 1'b1; single_idx = 2'd3; end
            4'b1011: begin single = 1'b1; single_idx = 2'd2; end
            4'b1101: begin single = 1'b1; single_idx = 2'd1; end
            4'b1110: begin single = 1'b1; single_idx = 2'd0; end
            default: ;
        endcase
    end

    assign press_mask = ~(4'b0001 << col_sel_q);
    assign rows_next  = {rows_q[0], rows_q[3:1]};
    assign db_inc     = db_cnt_q + 1'b1;
    assign new_code   = key_decode(row_sel_q, col_sel_q);

    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        row_sel_d   = row_sel_q;
        col_sel_d   = col_sel_q;
        db_cnt_d    = db_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        digit_hi_d  = digit_hi_q;
        digit_lo_d  = digit_lo_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (single) begin
                        row_sel_d = rows_q;
                        col_sel_d = single_idx;
                        db_cnt_d  = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        rows_d = rows_next;
                    end
                end
                DEBOUNCE: begin
                    if (col_s_q == press_mask) begin
                        db_cnt_d = db_inc;
                        if (db_inc == DB_LAST) begin
                            db_cnt_d    = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = new_code;
                            digit_hi_d  = digit_lo_q;
                            digit_lo_d  = new_code;
                            state_d     = HELD;
                        end
                    end else begin
                        db_cnt_d = '0;
                        rows_d   = rows_next;
                        state_d  = SCAN;
                    end
                end
                HELD: begin
                    if (col_s_q[col_sel_q]) begin
                        db_cnt_d = '0;
                        state_d  = RELEASE;
                    end
                end
                RELEASE: begin
                    if (col_s_q[col_sel_q]) begin
                        db_cnt_d = db_inc;
                        if (db_inc == DB_LAST) begin
                            db_cnt_d = '0;
                            rows_d   = rows_next;
                            state_d  = SCAN;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_m_q     <= 4'hF;
            col_s_q     <= 4'hF;
            state_q     <= SCAN;
            rows_q      <= ROW_TOP;
            row_sel_q   <= ROW_TOP;
            col_sel_q   <= 2'd0;
            db_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digit_hi_q  <= 4'h0;
            digit_lo_q  <= 4'h0;
        end else begin
            col_m_q     <= columns;
            col_s_q     <= col_m_q;
            state_q     <= state_d;
            rows_q      <= rows_d;
            row_sel_q   <= row_sel_d;
            col_sel_q   <= col_sel_d;
            db_cnt_q    <= db_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_hi_q  <= digit_hi_d;
            digit_lo_q  <= digit_lo_d;
        end
    end

    assign rows      = rows_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digit_hi  = digit_hi_q;
    assign digit_lo  = digit_lo_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DB_TICKS=3.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] columns;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit_hi;
    logic [3:0] digit_lo;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DB_TICKS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .columns   (columns),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digit_hi  (digit_hi),
        .digit_lo  (digit_lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_valid === 1'b1) pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge right after rows turns to target (first leaving target if already there).
    task automatic wait_for_row(input logic [3:0] target);
        int n = 0;
        while (rows === target && n < 64) begin @(negedge clk); n++; end
        while (rows !== target && n < 64) begin @(negedge clk); n++; end
        if (rows !== target) chk("row_wait", {28'd0, rows}, {28'd0, target});
    endtask

    task automatic press_key(input logic [3:0] row, input logic [3:0] cols,
                             input logic [3:0] code, input string tag);
        wait_for_row(row);
        columns = cols;
        clk_n(15);
        chk({tag, "_kv_early"}, key_valid, 1'b0);
        clk_n(1);
        chk({tag, "_kv_pulse"}, key_valid, 1'b1);
        chk({tag, "_code"}, key_code, code);
        clk_n(1);
        chk({tag, "_kv_after"}, key_valid, 1'b0);
        clk_n(3);
        chk({tag, "_rows_held"}, rows, row);
        columns = 4'hF;
        clk_n(15);
        chk({tag, "_rows_rel"}, rows, row);
        clk_n(1);
        chk({tag, "_rows_next"}, rows, {row[0], row[3:1]});
    endtask

    initial begin
        reset   = 1'b1;
        columns = 4'hF;
        clk_n(3);
        chk("rst_rows", rows, 4'b1000);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_hi", digit_hi, 4'h0);
        chk("rst_lo", digit_lo, 4'h0);
        reset = 1'b0;

        // idle scan
        clk_n(3);
        chk("scan_3", rows, 4'b1000);
        clk_n(1);
        chk("scan_4", rows, 4'b0100);
        clk_n(8);
        chk("scan_12", rows, 4'b0001);
        clk_n(4);
        chk("scan_16", rows, 4'b1000);
        chk("scan_pulses", pulses, 0);

        // key 6
        press_key(4'b0100, 4'b1101, 4'h6, "k6");
        chk("k6_lo", digit_lo, 4'h6);
        chk("k6_hi", digit_hi, 4'h0);
        chk("k6_pulses", pulses, 1);

        // key 5 then key 9
        press_key(4'b0100, 4'b1011, 4'h5, "k5");
        press_key(4'b0010, 4'b1101, 4'h9, "k9");
        chk("k59_hi", digit_hi, 4'h5);
        chk("k59_lo", digit_lo, 4'h9);
        chk("k59_pulses", pulses, 3);

        // long hold of D, then release with one bounce tick
        wait_for_row(4'b0001);
        columns = 4'b1110;
        clk_n(16);
        chk("kD_pulse", key_valid, 1'b1);
        chk("kD_code", key_code, 4'hD);
        clk_n(64);
        chk("kD_rows_held", rows, 4'b0001);
        chk("kD_hi", digit_hi, 4'h9);
        chk("kD_lo", digit_lo, 4'hD);
        columns = 4'hF;
        clk_n(9);
        columns = 4'b1110;
        clk_n(2);
        columns = 4'hF;
        clk_n(16);
        chk("kD_bounce_rows", rows, 4'b0001);
        clk_n(1);
        chk("kD_resume", rows, 4'b1000);
        chk("kD_pulses", pulses, 4);

        // short glitch: two low ticks then high
        wait_for_row(4'b1000);
        columns = 4'b0111;
        clk_n(9);
        columns = 4'hF;
        clk_n(2);
        chk("glitch_rows_hold", rows, 4'b1000);
        clk_n(1);
        chk("glitch_rows_next", rows, 4'b0100);
        clk_n(8);
        chk("glitch_pulses", pulses, 4);

        // two keys in one row: ignored, scan continues
        wait_for_row(4'b0100);
        columns = 4'b1001;
        clk_n(4);
        chk("dual_rows", rows, 4'b0010);
        clk_n(12);
        chk("dual_pulses", pulses, 4);
        chk("dual_code", key_code, 4'hD);

        // reset during debounce
        columns = 4'hF;
        wait_for_row(4'b0010);
        columns = 4'b1110;
        clk_n(8);
        chk("mid_db_rows", rows, 4'b0010);
        reset = 1'b1;
        clk_n(1);
        chk("mid_rst_rows", rows, 4'b1000);
        chk("mid_rst_kv", key_valid, 1'b0);
        chk("mid_rst_code", key_code, 4'h0);
        chk("mid_rst_hi", digit_hi, 4'h0);
        chk("mid_rst_lo", digit_lo, 4'h0);
        columns = 4'hF;
        reset = 1'b0;
        clk_n(20);
        chk("mid_rst_pulses", pulses, 4);
        chk("mid_rst_code2", key_code, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
